fft_stage_scheduler: RTL and testbench
======================================

// Module: fft_stage_scheduler
// PURPOSE
//   Sequences an in-place radix-2 DIT FFT of 2**N_LOG2 points over a shared sample RAM.
//   Per stage, issues one butterfly pair per cycle: RAM read addresses, twiddle index,
//   and butterfly-type select, plus write-back addresses delayed to match RAM+butterfly
//   latency. Sits between the control CPU/start logic and the butterfly datapath/RAM.
// PARAMETERS
//   N_LOG2      4   log2 of FFT size N (N=16 default); legal 2..12
//   RD_LATENCY  1   RAM read latency, cycles
//   BF_LATENCY  1   butterfly pipeline latency, cycles (type-2 unit = 1)
//   AW          N_LOG2    (localparam) address width
//   D           RD_LATENCY+BF_LATENCY  (localparam) issue-to-writeback delay
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   en         in   1        advance enable; low freezes FSM, counters and delay line
//   start      in   1        pulse; accepted only in IDLE
//   busy       out  1        high in RUN/DRAIN
//   done       out  1        1-cycle pulse on completion
//   rd_en      out  1        RAM read strobe
//   rd_addr0   out  AW       upper-leg address
//   rd_addr1   out  AW       lower-leg address
//   tw_idx     out  AW-1     twiddle ROM index, aligned with rd_en
//   bf_sel     out  2        0: W=1 trivial, 1: type-2 (tw_idx==N/4), 2: general multiply
//   wr_en      out  1        RAM write strobe (rd_en delayed D enabled cycles)
//   wr_addr0   out  AW       rd_addr0 delayed D enabled cycles
//   wr_addr1   out  AW       rd_addr1 delayed D enabled cycles
// BEHAVIOUR
//   - Reset: all outputs 0, FSM=IDLE, stage=0, k=0, delay line cleared.
//     Reset mid-run aborts: no further rd_en/wr_en, no done.
//   - FSM: IDLE -start&en-> RUN; RUN -(k==N/2-1)&en-> DRAIN; DRAIN -(D cycles)->
//     RUN(stage+1) or DONE if stage==N_LOG2-1; DONE -> IDLE (one enabled cycle).
//   - Addressing, stage s, butterfly k in 0..N/2-1: span=1<<s; pos=k&(span-1);
//     rd_addr0=((k>>s)<<(s+1))|pos; rd_addr1=rd_addr0+span; tw_idx=pos<<(N_LOG2-1-s).
//   - bf_sel: 0 if tw_idx==0; 1 if tw_idx==N/4; else 2.
//   - Timing: rd_en high in every RUN cycle with en=1. The first issue is the cycle after start
//     is accepted.
//   - DRAIN lasts exactly D enabled cycles so the last write of stage s lands before the
//     first read of stage s+1 (RAW hazard). Per stage: N/2+D cycles. Total: N_LOG2*(N/2+D).
//   - done is asserted in the cycle after the final DRAIN; busy is low in that cycle.
//   - en=0: state, k, stage and delay-line contents hold; rd_en=wr_en=0 that cycle;
//     address outputs hold their last value.
//   - start while busy or in DONE: ignored, not queued.
//   - start in the same cycle as rst: reset wins.
//   - k and stage counters wrap to 0 at stage/run end; no overflow past N_LOG2-1.
// CONFIGURATION
//   FFT_SCHED_STATUS_EN defined: adds outputs stage_done (out, 1; 1-cycle pulse at the
//     last DRAIN cycle of each stage) and cur_stage (out, $clog2(N_LOG2); current stage,
//     0 in IDLE). Both reset to 0.
//   FFT_SCHED_STATUS_EN undefined: neither port exists; core behaviour identical.
// TESTING
//   1. N_LOG2=4, en=1, start pulse -> 40 busy cycles, 32 rd_en, 32 wr_en; done at cycle 41.
//   2. Stage 2 -> k=5 gives rd_addr0=9, rd_addr1=13, tw_idx=2, bf_sel=2.
//      Stage 1 -> k=1 gives tw_idx=4, bf_sel=1.
//   3. Every wr_addr0/1 equals rd_addr0/1 from 2 enabled cycles earlier. Per stage, all 16
//      addresses are written exactly once.
//   4. en toggled 1010... for the whole run -> same address sequence as scenario 1; done after
//      80 cycles; no rd_en/wr_en while en=0.
//   5. rst pulsed at stage 1, k=3 -> outputs 0 immediately; a new start runs a full 40-cycle
//      transform from stage 0.
//   6. start re-pulsed mid-run and in the DONE cycle -> ignored. With FFT_SCHED_STATUS_EN:
//      stage_done pulses at cycles 10, 20, 30, 40.

Source files
------------

// File: rtl/fft_stage_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_stage_scheduler_if
//  Purpose  : Control and RAM-address bus of the FFT stage scheduler.
//             The master side (control logic) drives en/start. The slave
//             side (the scheduler) drives status, read/twiddle issue and
//             write-back signals.
//  Revision : 1.0  initial release
// ============================================================================
interface fft_stage_scheduler_if #(
    parameter int N_LOG2 = 4
);
    localparam int AW = N_LOG2;

    logic          en;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr0;
    logic [AW-1:0] rd_addr1;
    logic [AW-2:0] tw_idx;
    logic [1:0]    bf_sel;
    logic          wr_en;
    logic [AW-1:0] wr_addr0;
    logic [AW-1:0] wr_addr1;

    modport master (
        output en, start,
        input  busy, done, rd_en, rd_addr0, rd_addr1, tw_idx, bf_sel,
               wr_en, wr_addr0, wr_addr1
    );

    modport slave (
        input  en, start,
        output busy, done, rd_en, rd_addr0, rd_addr1, tw_idx, bf_sel,
               wr_en, wr_addr0, wr_addr1
    );
endinterface
`default_nettype wire

// File: rtl/fft_stage_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fft_stage_scheduler
//  Purpose  : Sequences an in-place radix-2 DIT FFT of 2**N_LOG2 points.
//             Issues one butterfly (two read addresses, twiddle index,
//             butterfly type) per enabled RUN cycle. Write-back addresses
//             trail the reads by RD_LATENCY+BF_LATENCY enabled cycles.
//             A DRAIN phase of the same length separates stages so that the
//             last write of a stage lands before the next stage reads.
//  Options  : FFT_SCHED_STATUS_EN adds the stage_done and cur_stage outputs.
//  Revision : 1.0  initial release
// ============================================================================
module fft_stage_scheduler #(
    parameter int N_LOG2     = 4,
    parameter int RD_LATENCY = 1,
    parameter int BF_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    fft_stage_scheduler_if.slave        bus
`ifdef FFT_SCHED_STATUS_EN
    ,
    output logic                        stage_done,
    output logic [$clog2(N_LOG2)-1:0]   cur_stage
`endif
);

    localparam int AW   = N_LOG2;
    localparam int D    = RD_LATENCY + BF_LATENCY;
    localparam int HALF = 1 << (N_LOG2 - 1);
    localparam int SW   = $clog2(N_LOG2);
    localparam int DW   = $clog2(D + 1);
    localparam logic [AW-2:0] TW_QUARTER = (AW-1)'(1 << (N_LOG2 - 2));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [AW-2:0] tw;
        logic [1:0]    sel;
    } issue_t;

    state_t        state;
    logic [AW-2:0] k;
    logic [SW-1:0] stage;
    logic [DW-1:0] dcnt;
    issue_t        iss;
    issue_t        nxt;
    logic [SW-1:0] nxt_s;
    logic [AW-2:0] nxt_k;

    logic [D-1:0]           dl_en;
    logic [D-1:0][AW-1:0]   dl_a0;
    logic [D-1:0][AW-1:0]   dl_a1;

    // Butterfly k of stage s: the upper leg is k with a zero inserted at bit
    // position s, the lower leg sits one span above it.
    function automatic issue_t calc_issue(input logic [SW-1:0] s,
                                          input logic [AW-2:0] kk);
        logic [AW-1:0] kx;
        logic [AW-1:0] span;
        logic [AW-1:0] pos;
        int            sh;
        issue_t        r;
        kx    = {1'b0, kk};
        span  = AW'(1) << s;
        pos   = kx & (span - AW'(1));
        r.a0  = (((kx >> s) << s) << 1) | pos;
        r.a1  = r.a0 + span;
        sh    = N_LOG2 - 1 - int'(s);
        r.tw  = (AW-1)'(pos << sh);
        if (r.tw == '0)
            r.sel = 2'd0;
        else if (r.tw == TW_QUARTER)
            r.sel = 2'd1;
        else
            r.sel = 2'd2;
        return r;
    endfunction

    // Butterfly that becomes current after the next enabled edge.
    always_comb begin
        nxt_s = stage;
        nxt_k = k + 1'b1;
        if (state == IDLE) begin
            nxt_s = '0;
            nxt_k = '0;
        end else if (state == DRAIN) begin
            nxt_s = stage + 1'b1;
            nxt_k = '0;
        end
        nxt = calc_issue(nxt_s, nxt_k);
    end

    // Stage/butterfly sequencer; issue registers load whenever RUN is entered
    // or advances, so they hold through en=0 and DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            stage <= '0;
            dcnt  <= '0;
            iss   <= '0;
        end else if (bus.en) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                        k     <= '0;
                        stage <= '0;
                        iss   <= nxt;
                    end
                end
                RUN: begin
                    if (k == (AW-1)'(HALF - 1)) begin
                        state <= DRAIN;
                        k     <= '0;
                        dcnt  <= '0;
                    end else begin
                        k     <= k + 1'b1;
                        iss   <= nxt;
                    end
                end
                DRAIN: begin
                    if (dcnt == DW'(D - 1)) begin
                        dcnt <= '0;
                        if (stage == SW'(N_LOG2 - 1)) begin
                            state <= DONE;
                            stage <= '0;
                        end else begin
                            state <= RUN;
                            stage <= stage + 1'b1;
                            iss   <= nxt;
                        end
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-back delay line: advances only on enabled cycles so writes stay
    // aligned with the data that the RAM and butterfly pipeline hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_en <= '0;
            dl_a0 <= '0;
            dl_a1 <= '0;
        end else if (bus.en) begin
            dl_en[0] <= bus.rd_en;
            dl_a0[0] <= iss.a0;
            dl_a1[0] <= iss.a1;
            for (int i = 1; i < D; i++) begin
                dl_en[i] <= dl_en[i-1];
                dl_a0[i] <= dl_a0[i-1];
                dl_a1[i] <= dl_a1[i-1];
            end
        end
    end

    assign bus.busy     = (state == RUN) || (state == DRAIN);
    assign bus.done     = (state == DONE) && bus.en;
    assign bus.rd_en    = (state == RUN) && bus.en;
    assign bus.rd_addr0 = iss.a0;
    assign bus.rd_addr1 = iss.a1;
    assign bus.tw_idx   = iss.tw;
    assign bus.bf_sel   = iss.sel;
    assign bus.wr_en    = dl_en[D-1] && bus.en;
    assign bus.wr_addr0 = dl_a0[D-1];
    assign bus.wr_addr1 = dl_a1[D-1];

`ifdef FFT_SCHED_STATUS_EN
    assign stage_done = (state == DRAIN) && (dcnt == DW'(D - 1)) && bus.en;
    assign cur_stage  = stage;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_stage_scheduler
//  Purpose  : Self-checking bench for fft_stage_scheduler (N=16, D=2).
//             Expected butterflies come from an enumeration of address pairs
//             per stage; timing follows the per-stage N/2+D cycle budget.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_stage_scheduler;

    localparam int N_LOG2 = 4;
    localparam int N      = 1 << N_LOG2;
    localparam int HALF   = N / 2;
    localparam int D      = 2;
    localparam int SLOT   = HALF + D;
    localparam int TOTAL  = N_LOG2 * SLOT;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fft_stage_scheduler_if #(.N_LOG2(N_LOG2)) bus ();

`ifdef FFT_SCHED_STATUS_EN
    logic       stage_done;
    logic [1:0] cur_stage;
`endif

    fft_stage_scheduler #(
        .N_LOG2     (N_LOG2),
        .RD_LATENCY (1),
        .BF_LATENCY (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef FFT_SCHED_STATUS_EN
        ,
        .stage_done (stage_done),
        .cur_stage  (cur_stage)
`endif
    );

    int total = 0;
    int bad   = 0;

    int q_a0[$];
    int q_a1[$];
    int q_tw[$];
    int q_sel[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: every stage pairs each index a having bit s clear with a+span,
    // in ascending order of a; twiddle = (a mod span) * N/(2*span).
    task automatic build_model();
        int span;
        int tw;
        for (int s = 0; s < N_LOG2; s++) begin
            span = 1 << s;
            for (int a = 0; a < N; a++) begin
                if ((a & span) == 0) begin
                    tw = (a % span) * (N / (2 * span));
                    q_a0.push_back(a);
                    q_a1.push_back(a + span);
                    q_tw.push_back(tw);
                    q_sel.push_back(tw == 0 ? 0 : (tw == N / 4 ? 1 : 2));
                end
            end
        end
    endtask

    // mode 0: en always 1; mode 1: en 0101... after accept; mode 2: random en
    // and random (ignored) start pulses. abort_p != 0 pulses rst at that step.
    task automatic run_one(input int mode, input int abort_p);
        int   p, cyc, busy_cnt, rd_cnt, wr_cnt, done_cyc;
        int   j, st, idx, pw, jw, idxw;
        logic e, in_run, wr_run;
        int   seen[N_LOG2][N];
        for (int s = 0; s < N_LOG2; s++)
            for (int a = 0; a < N; a++)
                seen[s][a] = 0;
        busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; done_cyc = -1;
        idxw = 0;

        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.en    = 1'b1;
        @(posedge clk);
        p = 1;
        cyc = 1;
        while (p <= TOTAL + 1 && cyc < 1000) begin
            #1;
            bus.start = (p == 20) || (p == TOTAL + 1) ||
                        (mode == 2 && p <= TOTAL && $urandom_range(0, 3) == 0);
            case (mode)
                0:       bus.en = 1'b1;
                1:       bus.en = (cyc % 2 == 0);
                default: bus.en = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            e      = bus.en;
            j      = (p - 1) % SLOT;
            st     = (p - 1) / SLOT;
            in_run = (p <= TOTAL) && (j < HALF);
            idx    = st * HALF + j;
            wr_run = 1'b0;
            if (p > D && p - D <= TOTAL) begin
                pw     = p - D;
                jw     = (pw - 1) % SLOT;
                wr_run = (jw < HALF);
                idxw   = ((pw - 1) / SLOT) * HALF + jw;
            end

            chk("busy",  32'(bus.busy),  32'(p <= TOTAL));
            chk("rd_en", 32'(bus.rd_en), 32'(e && in_run));
            chk("wr_en", 32'(bus.wr_en), 32'(e && wr_run));
            chk("done",  32'(bus.done),  32'(e && p == TOTAL + 1));
            if (in_run) begin
                chk("rd_addr0", 32'(bus.rd_addr0), q_a0[idx]);
                chk("rd_addr1", 32'(bus.rd_addr1), q_a1[idx]);
                chk("tw_idx",   32'(bus.tw_idx),   q_tw[idx]);
                chk("bf_sel",   32'(bus.bf_sel),   q_sel[idx]);
            end
            if (wr_run) begin
                chk("wr_addr0", 32'(bus.wr_addr0), q_a0[idxw]);
                chk("wr_addr1", 32'(bus.wr_addr1), q_a1[idxw]);
            end
            if (mode == 0 && in_run && p == 26) begin
                chk("s2k5_addr0", 32'(bus.rd_addr0), 9);
                chk("s2k5_addr1", 32'(bus.rd_addr1), 13);
                chk("s2k5_tw",    32'(bus.tw_idx),   2);
                chk("s2k5_sel",   32'(bus.bf_sel),   2);
            end
            if (mode == 0 && in_run && p == 12) begin
                chk("s1k1_tw",  32'(bus.tw_idx), 4);
                chk("s1k1_sel", 32'(bus.bf_sel), 1);
            end
`ifdef FFT_SCHED_STATUS_EN
            chk("stage_done", 32'(stage_done), 32'(e && p <= TOTAL && j == SLOT - 1));
            chk("cur_stage",  32'(cur_stage),  (p <= TOTAL) ? st : 0);
`endif
            if (bus.busy === 1'b1)  busy_cnt++;
            if (bus.rd_en === 1'b1) rd_cnt++;
            if (bus.wr_en === 1'b1) begin
                wr_cnt++;
                if (p > D && p - D <= TOTAL) begin
                    seen[(p - D - 1) / SLOT][bus.wr_addr0]++;
                    seen[(p - D - 1) / SLOT][bus.wr_addr1]++;
                end
            end
            if (bus.done === 1'b1 && done_cyc < 0) done_cyc = cyc;

            if (abort_p != 0 && p == abort_p) begin
                bus.start = 1'b0;
                #1 rst = 1'b1;
                #1;
                chk("abort_busy",  32'(bus.busy),     0);
                chk("abort_rd_en", 32'(bus.rd_en),    0);
                chk("abort_wr_en", 32'(bus.wr_en),    0);
                chk("abort_done",  32'(bus.done),     0);
                chk("abort_addr1", 32'(bus.rd_addr1), 0);
                chk("abort_tw",    32'(bus.tw_idx),   0);
                chk("abort_wa1",   32'(bus.wr_addr1), 0);
                #1 rst = 1'b0;
                @(posedge clk);
                #1;
                chk("abort_idle_busy", 32'(bus.busy),  0);
                chk("abort_idle_rd",   32'(bus.rd_en), 0);
                chk("abort_idle_wr",   32'(bus.wr_en), 0);
                return;
            end
            @(posedge clk);
            cyc++;
            if (e) p++;
        end
        chk("run_bound", p, TOTAL + 2);

        #1;
        bus.start = 1'b0;
        bus.en    = 1'b1;
        #1;
        chk("idle_busy", 32'(bus.busy),  0);
        chk("idle_done", 32'(bus.done),  0);
        chk("idle_rd",   32'(bus.rd_en), 0);

        chk("rd_count", rd_cnt, 32);
        chk("wr_count", wr_cnt, 32);
        if (mode == 0) begin
            chk("busy_cycles", busy_cnt, 40);
            chk("done_cycle",  done_cyc, 41);
            for (int s = 0; s < N_LOG2; s++)
                for (int a = 0; a < N; a++)
                    chk("write_once", seen[s][a], 1);
        end else if (mode == 1) begin
            chk("busy_cycles_tog", busy_cnt, 80);
            chk("done_cycle_tog",  done_cyc, 82);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.start = 1'b1;
        build_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(bus.busy),     0);
        chk("rst_done",  32'(bus.done),     0);
        chk("rst_rd_en", 32'(bus.rd_en),    0);
        chk("rst_wr_en", 32'(bus.wr_en),    0);
        chk("rst_addr0", 32'(bus.rd_addr0), 0);
        chk("rst_addr1", 32'(bus.rd_addr1), 0);
        chk("rst_tw",    32'(bus.tw_idx),   0);
        chk("rst_sel",   32'(bus.bf_sel),   0);
        chk("rst_wa0",   32'(bus.wr_addr0), 0);
        chk("rst_wa1",   32'(bus.wr_addr1), 0);
`ifdef FFT_SCHED_STATUS_EN
        chk("rst_stage_done", 32'(stage_done), 0);
        chk("rst_cur_stage",  32'(cur_stage),  0);
`endif
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_no_start", 32'(bus.busy), 0);

        run_one(0, 0);
        run_one(1, 0);
        run_one(0, SLOT + 3 + 1);
        run_one(0, 0);
        run_one(2, 0);
        run_one(2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
